ins_cache: RTL
==============

# ins_cache

Direct-mapped, read-only instruction cache between the CPU fetch stage and the 16-byte-block instruction memory. It serves 32-bit instruction words on a hit with no stall. On a miss it stalls the CPU via `busywait`, fetches the whole 128-bit block from instruction memory, installs it, and then serves the word. It holds no dirty state and performs no write-back.

## Interface
- `INDEX_BITS`, default 3: index width, giving 2^INDEX_BITS lines of 16 bytes each. The tag width is 6-INDEX_BITS.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the rising edge of `clock`.
- `read`  in  1  CPU fetch request; held high while `busywait` is high.
- `address`  in  10  CPU byte address (PC[9:0]). Bits [1:0] are ignored. Must stay stable while `busywait` is high.
- `instruction`  out  32  fetched instruction word.
- `busywait`  out  1  CPU stall request.
- `mem_read`  out  1  block read request to instruction memory.
- `mem_address`  out  6  block address, equal to `address[9:4]`.
- `mem_readdata`  in  128  block from memory; byte k of the block is at bits [8k+7:8k].
- `mem_busywait`  in  1  memory busy. Memory raises it as soon as `mem_read` rises and drops it when `mem_readdata` is valid.

## Operation
- Address split:
  - tag = `address[9:4+INDEX_BITS]`
  - index = `address[3+INDEX_BITS:4]`
  - word offset = `address[3:2]`
- Each line stores: valid (1 bit), tag, data (128 bits).
- Hit means `read` is high, the line at index is valid, and its tag equals the address tag. The hit decision is combinational.
- Word select: offset n drives `instruction` = `data[32n+31:32n]`.
- FSM states are IDLE, MEM_READ and UPDATE.
- IDLE:
  - `mem_read`=0.
  - `busywait` = `read` && !hit, asserted combinationally.
  - On a miss, the next state is MEM_READ.
- MEM_READ:
  - `mem_read`=1, `mem_address`=`address[9:4]`, `busywait`=1.
  - Stay in this state for at least one full cycle.
  - Go to UPDATE on the first rising edge where `mem_busywait`=0 and MEM_READ has already lasted at least one cycle.
- UPDATE:
  - `mem_read`=0, `busywait`=1.
  - On the rising edge: data ← `mem_readdata`, tag ← address tag, valid ← 1. Next state is IDLE.
  - In the following cycle the access hits and `busywait` falls.
- `read`=0: `busywait`=0 and no fetch starts. `instruction` holds the selected line's word but is don't-care.
- Only valid lines are ever marked as hits. Stale data in an invalid line is never presented with `busywait`=0.
- There are no writes from the CPU side. The cache does not observe stores to instruction memory.

## Timing
- Reset values:
  - state = IDLE
  - all valid bits = 0
  - `mem_read` = 0
  - `busywait` = 0 when `read`=0
  - `instruction` is don't-care until the first fill
- Hit latency is 0 cycles: `instruction` is valid in the same cycle, and the CPU samples it at the next rising edge.
- Miss penalty = 1 (IDLE→MEM_READ) + memory latency in cycles + 1 (UPDATE). After that `busywait` is low in IDLE.
- Handshake rules:
  - `mem_address` is stable for the whole time `mem_read` is high.
  - `mem_read` drops in the cycle after `mem_busywait` is seen low.
  - `mem_readdata` is captured only on the MEM_READ→UPDATE edge or the UPDATE edge, never earlier.
- Reset asserted mid-miss (MEM_READ or UPDATE): the next state is IDLE, all lines are invalidated, `mem_read` is 0 from the next cycle, and the partially fetched block is discarded.
- A conflict miss (same index, different tag) overwrites the line. No other line is affected.
- The CPU changing `address` while `busywait`=1 is a protocol violation and its result is undefined. The bench checks that the CPU never does this.
- Address 0x3FC, the last word of the last block, maps to block 63, offset 3. There is no wrap into block 0.

## Test plan
- Reset, then `read`=1, `address`=0x000, with memory word 0 = 0x00040019. Required: `busywait`=1 immediately, `mem_read`=1 with `mem_address`=0. After memory completes plus the UPDATE cycle, `instruction`=0x00040019 and `busywait`=0.
- After that fill, fetch 0x004, 0x008 and 0x00C. Required: each hits with `busywait`=0 throughout, giving 0x00050023, 0x02060405 and 0x03060504, and `mem_read` stays 0.
- Fetch 0x010, then 0x014 (block 1, index 1). Required: one miss for the block, then a hit returning 0x02060405.
- Conflict test: fetch 0x000, then 0x080 (same index 0, tag 1), then 0x000 again. Required: three misses, each with `mem_address` 0, 8, 0 in turn.
- Assert `reset` for one cycle during MEM_READ of a fetch to 0x020. Required: `mem_read`=0 on the next cycle, state IDLE. A following fetch to 0x000 misses even though it was filled before the reset.
- Hold `read`=0 for 5 cycles with any `address`. Required: `busywait`=0 and `mem_read`=0 throughout.

Source files
------------

// File: rtl/ins_cache_if.sv
// CPU fetch port and instruction-memory block port of the instruction cache.
// The cache sits on the slave modport; the driving side (CPU + memory) uses master.
interface ins_cache_if;
    logic         read;
    logic [9:0]   address;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    modport slave (
        input  read, address, mem_readdata, mem_busywait,
        output instruction, busywait, mem_read, mem_address
    );

    modport master (
        output read, address, mem_readdata, mem_busywait,
        input  instruction, busywait, mem_read, mem_address
    );
endinterface

// File: rtl/ins_cache.sv
// Direct-mapped read-only instruction cache: 0-cycle hits, whole-block refill on miss.
// IDLE -> MEM_READ (block request) -> UPDATE (install line) -> IDLE.
module ins_cache #(
    parameter int INDEX_BITS = 3
) (
    input  logic        clock,
    input  logic        reset,
    ins_cache_if.slave  bus
);
    localparam int TAG_BITS  = 6 - INDEX_BITS;
    localparam int NUM_LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_e;

    state_e                state_q, state_d;
    logic                  first_q, first_d;
    logic [NUM_LINES-1:0]  valid_q, valid_d;
    logic [TAG_BITS-1:0]   tag_q  [NUM_LINES];
    logic [TAG_BITS-1:0]   tag_d  [NUM_LINES];
    logic [127:0]          data_q [NUM_LINES];
    logic [127:0]          data_d [NUM_LINES];

    logic [TAG_BITS-1:0]   addr_tag;
    logic [INDEX_BITS-1:0] idx;
    logic [1:0]            off;
    logic                  hit;
    logic [1:0]            unused_byte_off;

    assign addr_tag        = bus.address[9:4+INDEX_BITS];
    assign idx             = bus.address[3+INDEX_BITS:4];
    assign off             = bus.address[3:2];
    assign unused_byte_off = bus.address[1:0];
    assign hit             = bus.read && valid_q[idx] && (tag_q[idx] == addr_tag);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            first_q <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            valid_q <= valid_d;
        end
    end

    // Tag/data need no reset: a line is only trusted through its valid bit.
    always_ff @(posedge clock) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    // first_q marks the opening MEM_READ cycle, before memory has had a chance
    // to raise mem_busywait, so a still-low busywait there is not taken as done.
    always_comb begin
        state_d = state_q;
        first_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.read && !hit) begin
                    state_d = MEM_READ;
                    first_d = 1'b1;
                end
            end
            MEM_READ: if (!first_q && !bus.mem_busywait) state_d = UPDATE;
            UPDATE:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (state_q == UPDATE) begin
            valid_d[idx] = 1'b1;
            tag_d[idx]   = addr_tag;
            data_d[idx]  = bus.mem_readdata;
        end
    end

    always_comb begin
        bus.mem_read    = (state_q == MEM_READ);
        bus.mem_address = bus.address[9:4];
        bus.busywait    = (state_q == IDLE) ? (bus.read && !hit) : 1'b1;
        case (off)
            2'd0:    bus.instruction = data_q[idx][31:0];
            2'd1:    bus.instruction = data_q[idx][63:32];
            2'd2:    bus.instruction = data_q[idx][95:64];
            default: bus.instruction = data_q[idx][127:96];
        endcase
    end
endmodule
